// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the multi-channel clock-enable generator (clkdiv_multi).
package clkdiv_pkg;

    localparam int DIV_W_DEF       = 32;
    localparam int DEFAULT_DIV_DEF = 101;

    typedef logic [DIV_W_DEF-1:0] div_t;

    // Divisors 0 and 1 both mean "tick every cycle".
    function automatic div_t eff_div(input div_t d);
        return (d == '0) ? div_t'(1) : d;
    endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// Divisor configuration bus for clkdiv_multi: write strobe in, ack/err pulses back.
interface clkdiv_multi_if #(
    parameter int NCH   = 4,
    parameter int DIV_W = 32
);

    localparam int CH_W = $clog2(NCH) | 1;

    // cfg_we is a one-cycle strobe with no ready: the slave accepts every cycle and answers
    // the following cycle with exactly one of cfg_ack (cfg_ch in range) or cfg_err (out of range).
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ack;
    logic             cfg_err;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_div,
        input  cfg_ack,
        input  cfg_err
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ack,
        output cfg_err
    );

endinterface

// File: rtl/clkdiv_chan.sv
// One clock-enable channel: period counter, active/pending divisors, tick and optional wave.
// Define CLKDIV_WAVE_EN to build the square-wave flop; otherwise wave is tied low.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             tick,
    output logic             wave
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] pending_div;
    logic [DIV_W-1:0] pending_nxt;
    logic [DIV_W-1:0] eff;
    logic [DIV_W-1:0] last;
    logic             terminal;

    generate
        if (DIV_W == DIV_W_DEF) begin : g_pkg_eff
            assign eff = eff_div(active_div);
        end else begin : g_local_eff
            assign eff = (active_div == '0) ? ONE : active_div;
        end
    endgenerate

    // cnt stays in 0..E-1, so E-1 never underflows and the increment never wraps.
    assign last        = eff - ONE;
    assign terminal    = en && (cnt == last);
    assign pending_nxt = wr ? wr_div : pending_div;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt         <= '0;
            active_div  <= DIV_RST;
            pending_div <= DIV_RST;
            tick        <= 1'b0;
        end else begin
            pending_div <= pending_nxt;
            if (!en) begin
                cnt        <= '0;
                tick       <= 1'b0;
                active_div <= pending_nxt;
            end else if (terminal) begin
                // A write landing on the terminal cycle bypasses straight into the next period.
                cnt        <= '0;
                tick       <= 1'b1;
                active_div <= pending_nxt;
            end else begin
                cnt  <= cnt + ONE;
                tick <= 1'b0;
            end
        end
    end

`ifdef CLKDIV_WAVE_EN
    logic wave_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wave_q <= 1'b0;
        end else if (terminal) begin
            wave_q <= ~wave_q;
        end
    end

    assign wave = wave_q;
`else
    assign wave = 1'b0;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// NCH-channel programmable clock-enable generator; decodes divisor writes and gathers outputs.
// Define CLKDIV_WAVE_EN to add a per-channel square wave; otherwise wave is all zeros.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] ch_en,
    clkdiv_multi_if.slave  cfg,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] wave
);

    localparam int              CH_W  = $clog2(NCH) | 1;
    localparam logic [CH_W-1:0] NCH_L = CH_W'(NCH);

    logic           in_range;
    logic [NCH-1:0] wr_sel;

    assign in_range = (cfg.cfg_ch < NCH_L);

    // Out-of-range indices select nothing, so they can never alias onto a real channel.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg.cfg_we && in_range && (cfg.cfg_ch == CH_W'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg.cfg_ack <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_ack <= cfg.cfg_we && in_range;
            cfg.cfg_err <= cfg.cfg_we && !in_range;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clkdiv_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .en     (ch_en[i]),
            .wr     (wr_sel[i]),
            .wr_div (cfg.cfg_div),
            .tick   (tick[i]),
            .wave   (wave[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: expected tick times queued per phase, compared as ticks appear.
module tb_clkdiv_multi;

    localparam int NCH   = 4;
    localparam int DIV_W = 32;
    localparam int CH_W  = 3;
`ifdef CLKDIV_WAVE_EN
    localparam bit WAVE_ON = 1'b1;
`else
    localparam bit WAVE_ON = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] wave;

    clkdiv_multi_if #(.NCH(NCH), .DIV_W(DIV_W)) cfg_bus ();

    clkdiv_multi #(
        .NCH         (NCH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (101)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ch_en (ch_en),
        .cfg   (cfg_bus),
        .tick  (tick),
        .wave  (wave)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int             checks  = 0;
    int             errors  = 0;
    int             mon_t0  = 0;
    logic           mon_on  = 1'b0;
    logic [NCH-1:0] mon_mask = '0;
    int             stray   = 0;
    int             stray0  = 0;
    int             ack_cnt = 0;
    int             a0      = 0;
    logic [31:0]    exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // expected tick record: channel in the top byte, cycles since enable below
    function automatic logic [31:0] enc(input int c, input int t);
        return (32'(c) << 24) | 32'(t);
    endfunction

    // scoreboard monitor: every tick on a watched channel pops one expectation
    always @(negedge clk) begin
        if (cfg_bus.cfg_ack) ack_cnt++;
        if (mon_on) begin
            for (int c = 0; c < NCH; c++) begin
                if (tick[c] && mon_mask[c]) begin
                    if (exp_q.size() == 0)
                        check("tick_unexpected", enc(c, cyc - mon_t0), 32'hffff_ffff);
                    else
                        check("tick_time", enc(c, cyc - mon_t0), exp_q.pop_front());
                end else if (tick[c]) begin
                    stray++;
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input logic [31:0] div);
        cfg_bus.cfg_we  = 1'b1;
        cfg_bus.cfg_ch  = CH_W'(ch);
        cfg_bus.cfg_div = div;
        step();
        cfg_bus.cfg_we  = 1'b0;
        check("cfg_ack", {31'b0, cfg_bus.cfg_ack}, 32'((ch < NCH) ? 1 : 0));
        check("cfg_err", {31'b0, cfg_bus.cfg_err}, 32'((ch >= NCH) ? 1 : 0));
    endtask

    task automatic start_phase(input logic [NCH-1:0] mask);
        mon_t0   = cyc;
        mon_mask = mask;
        stray0   = stray;
        mon_on   = 1'b1;
        ch_en    = mask;
    endtask

    task automatic end_phase();
        @(negedge clk);
        #1;
        check("tick_missing", 32'(exp_q.size()), 32'd0);
        check("stray_tick", 32'(stray - stray0), 32'd0);
        mon_on = 1'b0;
        exp_q.delete();
        ch_en  = '0;
    endtask

    initial begin
        cfg_bus.cfg_we  = 1'b0;
        cfg_bus.cfg_ch  = '0;
        cfg_bus.cfg_div = '0;

        // 1: reset, then default divisor 101 on channel 0
        reset = 1'b0;
        repeat (3) step();
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_wave", 32'(wave), 32'd0);
        check("rst_ack",  {31'b0, cfg_bus.cfg_ack}, 32'd0);
        check("rst_err",  {31'b0, cfg_bus.cfg_err}, 32'd0);
        reset = 1'b1;
        a0 = ack_cnt;
        start_phase(4'b0001);
        exp_q.push_back(enc(0, 101));
        exp_q.push_back(enc(0, 202));
        exp_q.push_back(enc(0, 303));
        repeat (303) step();
        end_phase();
        check("t1_no_ack", 32'(ack_cnt - a0), 32'd0);

        // 2: program ch1 while disabled, then run
        cfg_write(1, 32'd5);
        step();
        check("ack_pulse_end", {31'b0, cfg_bus.cfg_ack}, 32'd0);
        start_phase(4'b0010);
        for (int t = 5; t <= 20; t += 5) exp_q.push_back(enc(1, t));
        repeat (20) step();
        end_phase();

        // 3a: mid-period write leaves the running period alone
        cfg_write(2, 32'd10);
        start_phase(4'b0100);
        repeat (4) step();
        cfg_write(2, 32'd3);
        exp_q.push_back(enc(2, 10));
        exp_q.push_back(enc(2, 13));
        exp_q.push_back(enc(2, 16));
        exp_q.push_back(enc(2, 19));
        repeat (14) step();
        end_phase();

        // 3b: write on the terminal-count cycle takes effect at once
        cfg_write(2, 32'd10);
        start_phase(4'b0100);
        repeat (9) step();
        cfg_write(2, 32'd3);
        exp_q.push_back(enc(2, 10));
        exp_q.push_back(enc(2, 13));
        exp_q.push_back(enc(2, 16));
        repeat (6) step();
        end_phase();

        // 4: D=0 then D=1 on ch3 -> tick every cycle
        cfg_write(3, 32'd0);
        start_phase(4'b1000);
        for (int k = 1; k <= 20; k++) exp_q.push_back(enc(3, k));
        for (int k = 1; k <= 20; k++) begin
            if (k == 8) cfg_write(3, 32'd1);
            else step();
            check("wave3", {31'b0, wave[3]}, 32'(WAVE_ON ? (k % 2) : 0));
        end
        end_phase();

        // 5: out-of-range channel index
        cfg_write(7, 32'd77);
        step();
        check("err_pulse_end", {31'b0, cfg_bus.cfg_err}, 32'd0);
        start_phase(4'b1010);
        for (int t = 1; t <= 10; t++) begin
            if (t % 5 == 0) exp_q.push_back(enc(1, t));
            exp_q.push_back(enc(3, t));
        end
        repeat (10) step();
        end_phase();

        // 6: reset mid-period, with a write in the reset cycle
        start_phase(4'b0001);
        repeat (50) step();
        reset           = 1'b0;
        cfg_bus.cfg_we  = 1'b1;
        cfg_bus.cfg_ch  = CH_W'(1);
        cfg_bus.cfg_div = 32'd9;
        step();
        cfg_bus.cfg_we  = 1'b0;
        check("rst2_tick", 32'(tick), 32'd0);
        check("rst2_wave", 32'(wave), 32'd0);
        check("rst2_ack",  {31'b0, cfg_bus.cfg_ack}, 32'd0);
        check("rst2_err",  {31'b0, cfg_bus.cfg_err}, 32'd0);
        reset = 1'b1;
        end_phase();
        start_phase(4'b0011);
        exp_q.push_back(enc(0, 101));
        exp_q.push_back(enc(1, 101));
        repeat (101) step();
        end_phase();

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
